// File: rtl/calc_mem_responder.sv
// rtl/calc_mem_responder.sv - DEPTH-word memory responder with registered reads and OOB flag
// Define CALC_MEM_CLEAR_EN to zero the array in a post-reset sweep before requests are served.
module calc_mem_responder #(
   parameter int ADDR_W        = 5,
   parameter int MEM_WORD_SIZE = 64,
   parameter int DEPTH         = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     read,
   input  logic [ADDR_W-1:0]        r_addr,
   output logic [MEM_WORD_SIZE-1:0] r_data,
   output logic                     rd_valid,
   input  logic                     write,
   input  logic [ADDR_W-1:0]        w_addr,
   input  logic [MEM_WORD_SIZE-1:0] w_data,
   output logic                     init_done,
   output logic                     req_drop,
   output logic                     err_oob
);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   state_t                   state_q, state_d;
   logic [MEM_WORD_SIZE-1:0] mem [DEPTH];
   logic                     r_in, w_in;
   logic                     mem_we;
   logic [ADDR_W-1:0]        mem_wa;
   logic [MEM_WORD_SIZE-1:0] mem_wd;

   assign r_in = {1'b0, r_addr} < DEPTH_W;
   assign w_in = {1'b0, w_addr} < DEPTH_W;

`ifdef CALC_MEM_CLEAR_EN
   localparam state_t            RESET_STATE = S_CLEAR;
   localparam logic [ADDR_W-1:0] CLR_LAST    = ADDR_W'(DEPTH - 1);
   logic [ADDR_W-1:0] clr_ptr_q;
   logic              clr_we;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clr_ptr_q <= '0;
      end else if (clr_we && (clr_ptr_q != CLR_LAST)) begin
         clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
      end
   end
`else
   localparam state_t RESET_STATE = S_READY;
`endif

   always_comb begin
      state_d = state_q;
`ifdef CALC_MEM_CLEAR_EN
      clr_we  = 1'b0;
`endif
      case (state_q)
         S_CLEAR: begin
`ifdef CALC_MEM_CLEAR_EN
            clr_we = 1'b1;
            if (clr_ptr_q == CLR_LAST) state_d = S_READY;
`else
            state_d = S_READY;
`endif
         end
         S_READY: state_d = S_READY;
         default: state_d = S_READY;
      endcase
   end

   // The sweep owns the write port until init_done; user writes only after.
   always_comb begin
      mem_we = init_done && write && w_in;
      mem_wa = w_addr;
      mem_wd = w_data;
`ifdef CALC_MEM_CLEAR_EN
      if (clr_we) begin
         mem_we = 1'b1;
         mem_wa = clr_ptr_q;
         mem_wd = '0;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RESET_STATE;
         init_done <= 1'b0;
         r_data    <= '0;
         rd_valid  <= 1'b0;
         req_drop  <= 1'b0;
         err_oob   <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_done <= (state_d == S_READY);
         rd_valid  <= init_done && read;
         req_drop  <= !init_done && (read || write);
         if (init_done && read) begin
            if (!r_in)                                  r_data <= '0;
            else if (write && w_in && w_addr == r_addr) r_data <= w_data;
            else                                        r_data <= mem[r_addr];
         end
         if (init_done && ((read && !r_in) || (write && !w_in))) err_oob <= 1'b1;
      end
   end

endmodule

// File: tb/tb_calc_mem_responder.sv
// tb/tb_calc_mem_responder.sv - scoreboard bench for calc_mem_responder (DEPTH=20)
module tb_calc_mem_responder;

   localparam int ADDR_W = 5;
   localparam int MW     = 64;
   localparam int DEPTH  = 20;
`ifdef CALC_MEM_CLEAR_EN
   localparam int INIT_EDGES = DEPTH;
`else
   localparam int INIT_EDGES = 1;
`endif

   logic              clk_i  = 1'b0;
   logic              rst_ni = 1'b0;
   logic              read   = 1'b0;
   logic [ADDR_W-1:0] r_addr = '0;
   logic [MW-1:0]     r_data;
   logic              rd_valid;
   logic              write  = 1'b0;
   logic [ADDR_W-1:0] w_addr = '0;
   logic [MW-1:0]     w_data = '0;
   logic              init_done;
   logic              req_drop;
   logic              err_oob;

   calc_mem_responder #(.ADDR_W(ADDR_W), .MEM_WORD_SIZE(MW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .read(read), .r_addr(r_addr), .r_data(r_data), .rd_valid(rd_valid),
      .write(write), .w_addr(w_addr), .w_data(w_data),
      .init_done(init_done), .req_drop(req_drop), .err_oob(err_oob)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: state as seen after the most recent edge.
   logic [MW-1:0] m_mem [DEPTH];
   logic [MW-1:0] exp_q [$];
   logic [MW-1:0] last_rd  = '0;
   bit            m_ready  = 1'b0;
   bit            m_oob    = 1'b0;
   bit            exp_drop = 1'b0;
   bit            mon_en   = 1'b0;
   int            m_edges  = 0;
   int            errors   = 0;
   int            checks   = 0;

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk_i) begin
      #1;
      if (mon_en) begin
         bit exp_v;
         exp_v = (exp_q.size() != 0);
         chk("rd_valid", rd_valid, exp_v);
         if (exp_v) last_rd = exp_q.pop_front();
         chk("r_data", r_data, last_rd);
         chk("req_drop", req_drop, exp_drop);
         chk("init_done", init_done, m_ready);
         chk("err_oob", err_oob, m_oob);
      end
   end

   // Called at a falling edge; drives one cycle and returns at the next falling edge.
   task automatic step(input bit rd, input logic [ADDR_W-1:0] ra,
                       input bit wr, input logic [ADDR_W-1:0] wa, input logic [MW-1:0] wd);
      read = rd; r_addr = ra; write = wr; w_addr = wa; w_data = wd;
      if (m_ready) begin
         if (wr && wa < DEPTH) m_mem[wa] = wd;
         if (rd) exp_q.push_back((ra < DEPTH) ? m_mem[ra] : '0);
         if ((rd && ra >= DEPTH) || (wr && wa >= DEPTH)) m_oob = 1'b1;
         exp_drop = 1'b0;
      end else begin
         exp_drop = rd | wr;
      end
      m_edges++;
      m_ready = (m_edges >= INIT_EDGES);
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, '0, '0);
   endtask

   task automatic rand_step(input int max_addr);
      logic [ADDR_W-1:0] ra, wa;
      ra = ADDR_W'($urandom_range(0, max_addr));
      wa = ADDR_W'($urandom_range(0, max_addr));
      if ($urandom_range(0, 3) == 0) wa = ra;
      step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom});
   endtask

   task automatic do_reset(input bit inflight);
      mon_en = 1'b0;
      read   = inflight;
      r_addr = 5'd3;
      write  = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_r_data", r_data, '0);
      chk("rst_rd_valid", rd_valid, '0);
      chk("rst_req_drop", req_drop, '0);
      chk("rst_err_oob", err_oob, '0);
      chk("rst_init_done", init_done, '0);
      @(posedge clk_i);
      #1 chk("rst_inflight_rd_valid", rd_valid, '0);
      read = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      exp_q.delete();
      m_ready  = 1'b0;
      m_oob    = 1'b0;
      exp_drop = 1'b0;
      m_edges  = 0;
      last_rd  = '0;
`ifdef CALC_MEM_CLEAR_EN
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
`endif
      mon_en = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk_i);
      do_reset(1'b0);
      step(1'b1, 5'd2, 1'b0, '0, '0);
      repeat (INIT_EDGES - 1) idle();
`ifdef CALC_MEM_CLEAR_EN
      step(1'b1, 5'd19, 1'b0, '0, '0);
`endif
      for (int a = 0; a < DEPTH; a++) step(1'b0, '0, 1'b1, ADDR_W'(a), {$urandom, $urandom});

      step(1'b0, '0, 1'b1, 5'd3, 64'h0000_0005_0000_0007);
      step(1'b1, 5'd3, 1'b0, '0, '0);
      step(1'b1, 5'd7, 1'b1, 5'd7, 64'hDEAD_BEEF_0000_0001);
      step(1'b1, 5'd4, 1'b1, 5'd9, 64'h1234_5678_9ABC_DEF0);
      step(1'b1, 5'd9, 1'b0, '0, '0);
      step(1'b1, 5'd19, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      repeat (300) rand_step(DEPTH - 1);

      step(1'b0, '0, 1'b1, 5'd25, 64'hAAAA_5555_AAAA_5555);
      step(1'b1, 5'd25, 1'b0, '0, '0);
      step(1'b1, 5'd5, 1'b0, '0, '0);
      step(1'b1, 5'd20, 1'b1, 5'd20, 64'h0BAD_0BAD_0BAD_0BAD);
      repeat (300) rand_step(31);

      step(1'b1, 5'd4, 1'b0, '0, '0);
      do_reset(1'b1);
      repeat (10) idle();
      do_reset(1'b1);
      repeat (INIT_EDGES) idle();
      for (int a = 0; a < DEPTH; a++) step(1'b1, ADDR_W'(a), 1'b0, '0, '0);
      repeat (100) rand_step(DEPTH - 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/calc_mem_responder.md
CALC_MEM_RESPONDER -- requirements
Module: calc_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, address width; it matches calculator_pkg ADDR_W.
REQ-002 The block SHALL have parameter MEM_WORD_SIZE, default 64, data word width; it matches calculator_pkg MEM_WORD_SIZE.
REQ-003 The block SHALL have parameter DEPTH, default 32, number of implemented words; legal range 1..2**ADDR_W.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port read, input, 1 bit: read request, sampled each cycle.
REQ-007 The block SHALL have port r_addr, input, ADDR_W bits: read address.
REQ-008 The block SHALL have port r_data, output, MEM_WORD_SIZE bits: registered read data.
REQ-009 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking new r_data.
REQ-010 The block SHALL have port write, input, 1 bit: write request, sampled each cycle.
REQ-011 The block SHALL have port w_addr, input, ADDR_W bits: write address.
REQ-012 The block SHALL have port w_data, input, MEM_WORD_SIZE bits: write data.
REQ-013 The block SHALL have port init_done, output, 1 bit: high when requests are being served.
REQ-014 The block SHALL have port req_drop, output, 1 bit: one-cycle pulse when a read or write request is discarded while init_done=0.
REQ-015 The block SHALL have port err_oob, output, 1 bit: sticky flag for any access with address >= DEPTH.

Function
REQ-016 Storage SHALL be DEPTH words of MEM_WORD_SIZE bits. The array itself has no reset.
REQ-017 The FSM SHALL have exactly two states, S_CLEAR and S_READY; S_READY is terminal until reset.
REQ-018 In S_READY, when write=1 at edge N with w_addr<DEPTH, mem[w_addr] SHALL take w_data at edge N.
REQ-019 In S_READY, when read=1 at edge N, r_data SHALL equal mem[r_addr] after edge N, and rd_valid SHALL be 1 for that one cycle only (latency 1).
REQ-020 r_data SHALL hold its value until the next accepted read.
REQ-021 When read and write are both 1 in the same cycle with r_addr==w_addr<DEPTH, r_data SHALL return the new w_data (write-first bypass).
REQ-022 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-023 A write with w_addr>=DEPTH SHALL be ignored and SHALL set err_oob.
REQ-024 A read with r_addr>=DEPTH SHALL return r_data=0, SHALL still pulse rd_valid, and SHALL set err_oob.
REQ-025 err_oob SHALL remain 1 until reset.
REQ-026 While init_done=0, read and write SHALL be ignored: no memory update, no rd_valid. req_drop SHALL pulse the following cycle for each cycle in which read|write=1.

Reset
REQ-027 While rst_ni=0, outputs SHALL immediately become r_data=0, rd_valid=0, req_drop=0, err_oob=0, init_done=0, and the clear pointer SHALL be 0.
REQ-028 The reset-exit state SHALL be S_CLEAR when CALC_MEM_CLEAR_EN is defined, otherwise S_READY.
REQ-029 If reset is asserted mid-operation, an in-flight read SHALL be lost (no rd_valid). Memory contents SHALL be retained unless they are cleared per REQ-031.

Configuration
REQ-030 Macro CALC_MEM_CLEAR_EN SHALL select the post-reset clear sweep.
REQ-031 With CALC_MEM_CLEAR_EN defined: S_CLEAR writes 0 to address 0 at the first edge after reset release, then one address per edge. At the DEPTH-th edge it writes DEPTH-1, enters S_READY and sets init_done=1.
REQ-032 Without CALC_MEM_CLEAR_EN: init_done SHALL be 1 after the first edge following reset release, memory is uninitialised, and the clear logic SHALL be absent.

Verification
REQ-033 Clear enabled, DEPTH=32: release reset, then count edges -> init_done=1 after edge 32; read addr 31 -> r_data=0, rd_valid for 1 cycle.
REQ-034 Write addr 3 with 64'h0000_0005_0000_0007, then read addr 3 on the next cycle -> r_data=64'h0000_0005_0000_0007 one cycle after the read.
REQ-035 Same-cycle write addr 7 with 64'hDEAD_BEEF_0000_0001 and read addr 7 -> r_data=64'hDEAD_BEEF_0000_0001 next cycle.
REQ-036 DEPTH=20: write addr 25, then read addr 25 -> err_oob=1 and stays 1; r_data=0; mem[5] is unchanged.
REQ-037 Clear enabled: assert read at edge 4 after reset release -> req_drop pulses once, no rd_valid.
REQ-038 Assert rst_ni=0 mid-sweep at edge 10, then release -> clear restarts from address 0 and init_done rises after 32 further edges.
